// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage register with stall, flush-to-RST_VAL and occupancy output.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid buffer with a registered upstream ready.
module pipe_stage_hs #(
  parameter int unsigned    DW      = 32,
  parameter logic [DW-1:0]  RST_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          hold_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [1:0]    level_o
);

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [DW-1:0]   main_q, main_d;
  logic            valid_int;
  logic            ready_int;
  logic            in_fire;
  logic            out_fire;

`ifdef PIPE_STAGE_SKID_EN
  logic [DW-1:0]   skid_q, skid_d;
  logic            ready_q, ready_d;

  // Upstream ready comes straight from a flop, breaking the ready chain.
  assign ready_int = ready_q;
`else
  assign ready_int = ~valid_int | out_ready_i;
`endif

  assign valid_int   = (state_q != ST_EMPTY);
  assign in_ready_o  = ready_int & ~hold_i;
  assign out_valid_o = valid_int & ~hold_i;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  assign out_data_o  = main_q;
  assign level_o     = 2'(state_q);

  // Next-state and payload steering; flush outranks every handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = RST_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data_i;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
`ifdef PIPE_STAGE_SKID_EN
          end else if (in_fire) begin
            state_d = ST_TWO;
            skid_d  = in_data_i;
`endif
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_TWO: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
`endif
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
`ifdef PIPE_STAGE_SKID_EN
    ready_d = (state_d != ST_TWO);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RST_VAL;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= {DW{1'b0}};
      ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= skid_d;
      ready_q <= ready_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs: directed scenarios plus randomized traffic
// compared against a queue-based reference model. Honours PIPE_STAGE_SKID_EN.
module tb_pipe_stage_hs;

  localparam int unsigned DW = 32;
  localparam logic [31:0] RV = 32'h0000_0013;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          hold;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    level;

  int n_cmp;
  int n_bad;

  // Reference model: items held, in order, plus the last value shown on out_data.
  logic [31:0] q[$];
  logic [31:0] last;

  pipe_stage_hs #(.DW(DW), .RST_VAL(RV)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .hold_i     (hold),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .level_o    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_ready();
    if (hold) return 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  function automatic logic [35:0] exp_vec();
    logic ev;
    ev = !hold && (q.size() > 0);
    return {exp_ready(), ev, 2'(q.size()), last};
  endfunction

  // Apply one cycle's inputs away from the clock edge and let outputs settle.
  task automatic drive(input logic fl, input logic hd, input logic iv,
                       input logic [31:0] d, input logic ordy);
    @(negedge clk);
    flush     = fl;
    hold      = hd;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  // Advance the model across the next rising edge.
  task automatic advance();
    logic ifire;
    logic ofire;
    logic [31:0] d;
    ifire = in_valid && exp_ready();
    ofire = !hold && (q.size() > 0) && out_ready;
    d = in_data;
    @(posedge clk);
    if (flush) begin
      q.delete();
      last = RV;
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(d);
    end
    if (q.size() > 0) last = q[0];
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; hold = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    q.delete();
    last = RV;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [35:0] obs;
    @(negedge clk);
    rst = 1'b1; hold = 1'b0;
    flush = 1'($urandom); in_valid = 1'b1; in_data = $urandom; out_ready = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    obs = {1'b0, out_valid, level, out_data};
    n_cmp++;
    if (obs !== {1'b0, 1'b0, 2'd0, RV}) begin
      n_bad++;
      $display("FAIL reset_held: got %h expected %h", obs, {1'b0, 1'b0, 2'd0, RV});
    end
    q.delete();
    last = RV;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    obs = {in_ready, out_valid, level, out_data};
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 2'd0, RV}) begin
      n_bad++;
      $display("FAIL reset_release: got %h expected %h", obs, {1'b1, 1'b0, 2'd0, RV});
    end
  endtask

  task automatic test_stream();
    logic [35:0] obs;
    logic [35:0] exp;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, i < 3, 32'h100 + 32'(4 * i), 1'b1);
      obs = {in_ready, out_valid, level, out_data};
      exp = exp_vec();
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL stream_model[%0d]: got %h expected %h", i, obs, exp);
      end
      if (i >= 1 && i <= 3) begin
        exp = {1'b1, 1'b1, 2'd1, 32'h100 + 32'(4 * (i - 1))};
        n_cmp++;
        if (obs !== exp) begin
          n_bad++;
          $display("FAIL stream_item[%0d]: got %h expected %h", i, obs, exp);
        end
      end
      advance();
    end
  endtask

`ifdef PIPE_STAGE_SKID_EN
  task automatic test_skid();
    logic [35:0] obs;
    logic [35:0] want[5];
    apply_reset();
    want[0] = {1'b1, 1'b0, 2'd0, RV};
    want[1] = {1'b1, 1'b1, 2'd1, 32'h0000_000A};
    want[2] = {1'b0, 1'b1, 2'd2, 32'h0000_000A};
    want[3] = {1'b0, 1'b1, 2'd2, 32'h0000_000A};
    want[4] = {1'b1, 1'b1, 2'd1, 32'h0000_000B};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, i < 2, (i == 0) ? 32'hA : 32'hB, i >= 3);
      obs = {in_ready, out_valid, level, out_data};
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL skid_model[%0d]: got %h expected %h", i, obs, exp_vec());
      end
      if (i < 5) begin
        n_cmp++;
        if (obs !== want[i]) begin
          n_bad++;
          $display("FAIL skid_step[%0d]: got %h expected %h", i, obs, want[i]);
        end
      end else begin
        n_cmp++;
        if ({out_valid, level, out_data} !== {1'b0, 2'd0, 32'h0000_000B}) begin
          n_bad++;
          $display("FAIL skid_drained: got %h expected %h",
                   {out_valid, level, out_data}, {1'b0, 2'd0, 32'h0000_000B});
        end
      end
      advance();
    end
  endtask
`else
  task automatic test_passthru();
    logic [35:0] obs;
    apply_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
    advance();
    drive(1'b0, 1'b0, 1'b1, 32'h21, 1'b0);
    obs = {in_ready, out_valid, level, out_data};
    n_cmp++;
    if (obs !== {1'b0, 1'b1, 2'd1, 32'h20}) begin
      n_bad++;
      $display("FAIL full_not_ready: got %h expected %h", obs, {1'b0, 1'b1, 2'd1, 32'h20});
    end
    advance();
    drive(1'b0, 1'b0, 1'b1, 32'h21, 1'b1);
    obs = {in_ready, out_valid, level, out_data};
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 2'd1, 32'h20}) begin
      n_bad++;
      $display("FAIL ready_follows: got %h expected %h", obs, {1'b1, 1'b1, 2'd1, 32'h20});
    end
    advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    obs = {in_ready, out_valid, level, out_data};
    n_cmp++;
    if (obs !== {1'b0, 1'b1, 2'd1, 32'h21}) begin
      n_bad++;
      $display("FAIL replace: got %h expected %h", obs, {1'b0, 1'b1, 2'd1, 32'h21});
    end
    advance();
  endtask
`endif

  task automatic test_flush();
    logic [35:0] obs;
    apply_reset();
    drive(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
    advance();
    drive(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
    advance();
    drive(1'b1, 1'b0, 1'b1, 32'hC, 1'b0);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      obs = {in_ready, out_valid, level, out_data};
      n_cmp++;
      if (obs !== {1'b1, 1'b0, 2'd0, RV}) begin
        n_bad++;
        $display("FAIL flush_empty[%0d]: got %h expected %h", i, obs, {1'b1, 1'b0, 2'd0, RV});
      end
      advance();
    end
  endtask

  task automatic test_hold();
    logic [35:0] obs;
    apply_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, $urandom, 1'b1);
      obs = {in_ready, out_valid, level, out_data};
      n_cmp++;
      if (obs !== {1'b0, 1'b0, 2'd1, 32'h55}) begin
        n_bad++;
        $display("FAIL hold_frozen[%0d]: got %h expected %h", i, obs, {1'b0, 1'b0, 2'd1, 32'h55});
      end
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    obs = {in_ready, out_valid, level, out_data};
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 2'd1, 32'h55}) begin
      n_bad++;
      $display("FAIL hold_release: got %h expected %h", obs, {1'b1, 1'b1, 2'd1, 32'h55});
    end
    advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    obs = {in_ready, out_valid, level, out_data};
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 2'd0, 32'h55}) begin
      n_bad++;
      $display("FAIL hold_drained: got %h expected %h", obs, {1'b1, 1'b0, 2'd0, 32'h55});
    end
    advance();
  endtask

  task automatic test_random();
    logic [35:0] obs;
    logic [35:0] exp;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 25) == 0, ($urandom % 6) == 0, 1'($urandom),
            $urandom, ($urandom % 3) != 0);
      obs = {in_ready, out_valid, level, out_data};
      exp = exp_vec();
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs, exp);
      end
      advance();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    last = RV;
    test_reset();
    test_stream();
`ifdef PIPE_STAGE_SKID_EN
    test_skid();
`else
    test_passthru();
`endif
    test_flush();
    test_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Parametrised pipeline stage register for the RV32 core pipeline (IF/ID, ID/EX boundaries).
- Successor to the plain set/flush flop. Adds a valid/ready handshake, a stall input, a flush that loads a NOP/reset value, and an occupancy output.
- An optional 2-entry skid buffer registers the upstream ready path, breaking the combinational ready chain through the pipeline.

Parameters:
- DW, 32, payload width in bits (instruction/PC/control bundle).
- RST_VAL, {DW{1'b0}}, value driven on out_data_o after reset and after flush (ID stage uses 32'h0000_0013, NOP).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- flush_i  input  1  jump/branch flush; drops all held entries
- hold_i  input  1  stall; freezes the stage, no transfers in either direction
- in_valid_i  input  1  upstream payload valid
- in_ready_o  output  1  stage can accept
- in_data_i  input  DW  upstream payload
- out_valid_o  output  1  payload valid to downstream
- out_ready_i  input  1  downstream accepts
- out_data_o  output  DW  payload to downstream
- level_o  output  2  entries held: 0, 1 or 2 (2 only with skid)

Behaviour:
- One clock; reset is synchronous and active-high: ports clk and rst.
- Reset, and every cycle rst is high:
  - state EMPTY, level_o=0, out_valid_o=0, out_data_o=RST_VAL.
  - Skid entry cleared; internal ready register=1.
  - Handshakes presented while rst is high are ignored.
- Transfer definitions:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
- Hold gating:
  - in_ready_o = ready_int & !hold_i.
  - out_valid_o = valid_int & !hold_i.
  - So no transfer occurs while hold_i=1. All state, including out_data_o, is unchanged.
- Flush, priority rst > flush_i > hold_i > handshakes:
  - Next state EMPTY, level_o=0, out_data_o<=RST_VAL.
  - Any in_fire in the flush cycle is discarded (upstream sees it completed).
  - Any out_fire in the flush cycle is still counted by downstream as delivered; downstream flushes itself.
- Latency: one cycle from in_fire to out_valid_o. Throughput is 1 item/cycle with out_ready_i=1. Strict FIFO order.
- out_data_o holds its last value when the stage empties through normal draining. Only rst and flush load RST_VAL.
- Without skid (2 states: EMPTY, FULL):
  - ready_int = !valid_int | out_ready_i. This is a combinational path from out_ready_i.
  - EMPTY --in_fire--> FULL: main <= in_data_i.
  - FULL with in_fire & out_fire: stays FULL, main <= in_data_i.
  - FULL with out_fire only: goes to EMPTY.
- With skid (3 states: EMPTY, ONE, TWO):
  - ready_int is registered and equals (next state != TWO).
  - EMPTY --in_fire--> ONE: main <= in.
  - ONE, in_fire & out_fire: stays ONE, main <= in.
  - ONE, in_fire & !out_fire: goes to TWO, skid <= in.
  - ONE, out_fire only: goes to EMPTY.
  - TWO: in_ready_o=0. On out_fire goes to ONE, main <= skid.
  - TWO never accepts input, so the buffer cannot overflow.
- level_o encoding: EMPTY=0, ONE/FULL=1, TWO=2.

Optional Feature:
- Macro PIPE_STAGE_SKID_EN.
- Defined: 3-state skid buffer as above. in_ready_o depends only on registers and hold_i. level_o can reach 2.
- Undefined: 2-state single register. in_ready_o combinationally follows out_ready_i. level_o is 0/1. No skid storage is synthesised.

Test Plan:
- Reset with DW=32, RST_VAL=32'h13, rst high 2 cycles -> out_valid_o=0, out_data_o=32'h13, level_o=0, in_ready_o=1 after release.
- Stream 0x100,0x104,0x108 on consecutive cycles, out_ready_i=1 -> each appears one cycle after accept, back-to-back, level_o=1 throughout.
- Skid on: accept 0xA, then 0xB with out_ready_i=0 -> level_o=2, in_ready_o=0 next cycle. Raise out_ready_i -> 0xA then 0xB delivered in order, level_o 2->1->0.
- State TWO holding 0xA/0xB; assert flush_i with in_valid_i=1, data 0xC -> next cycle level_o=0, out_valid_o=0, out_data_o=32'h13, 0xC never emitted.
- State ONE holding 0x55; hold_i=1 for 3 cycles, in_valid_i=1, out_ready_i=1 -> in_ready_o=0, out_valid_o=0, out_data_o stays 0x55. Release -> 0x55 delivered.
- Skid off: state FULL, out_ready_i=0 -> in_ready_o=0 same cycle. out_ready_i=1 with new input -> pass-through replace, level_o stays 1.
